// File: rtl/elastic_issue_stage.sv
// LANES-wide elastic issue-group stage: head register plus skid register with a
// registered in_ready. Supports per-lane squash of the head, whole-stage flush and bubble drop.
module elastic_issue_stage #(
  parameter int LANES        = 2,
  parameter int DATA_W       = 64,
  parameter int ZERO_ON_KILL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [LANES-1:0]        kill_mask,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_vld,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              occupancy
);

  logic                    h_valid_reg, h_valid_next;
  logic [LANES-1:0]        h_vld_reg, h_vld_next;
  logic [LANES*DATA_W-1:0] h_data_reg, h_data_next;
  logic                    s_valid_reg, s_valid_next;
  logic [LANES-1:0]        s_vld_reg, s_vld_next;
  logic [LANES*DATA_W-1:0] s_data_reg, s_data_next;
  logic                    in_ready_reg, in_ready_next;

  logic [LANES*DATA_W-1:0] h_data_kept;
  logic                    h_leave;
  logic                    store;

  // Head payload as it should look after this edge's kill_mask is applied.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign h_data_kept[gi*DATA_W +: DATA_W] =
        (ZERO_ON_KILL != 0 && kill_mask[gi]) ? '0 : h_data_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign out_lane_vld = h_vld_reg & ~kill_mask;
  assign out_valid    = h_valid_reg & (|out_lane_vld);
  assign out_data     = h_data_reg;
  assign in_ready     = in_ready_reg;
  assign occupancy    = {1'b0, h_valid_reg} + {1'b0, s_valid_reg};

  // A fully killed head leaves regardless of out_ready.
  assign h_leave = h_valid_reg & (~(|out_lane_vld) | out_ready);
  // Bubbles are accepted but never stored.
  assign store   = in_valid & in_ready_reg & (|in_lane_vld);

  always_comb begin
    h_valid_next = h_valid_reg;
    h_vld_next   = h_vld_reg;
    h_data_next  = h_data_reg;
    s_valid_next = s_valid_reg;
    s_vld_next   = s_vld_reg;
    s_data_next  = s_data_reg;

    if (flush) begin
      h_valid_next = 1'b0;
      h_vld_next   = '0;
      s_valid_next = 1'b0;
      s_vld_next   = '0;
      if (ZERO_ON_KILL != 0) begin
        h_data_next = '0;
        s_data_next = '0;
      end
    end else if (h_leave) begin
      if (s_valid_reg) begin
        h_valid_next = 1'b1;
        h_vld_next   = s_vld_reg;
        h_data_next  = s_data_reg;
        s_valid_next = store;
        s_vld_next   = store ? in_lane_vld : '0;
        if (store) s_data_next = in_data;
      end else begin
        h_valid_next = store;
        h_vld_next   = store ? in_lane_vld : '0;
        h_data_next  = store ? in_data : h_data_kept;
      end
    end else if (h_valid_reg) begin
      // Head stays; in_ready implies the skid slot is free for a new group.
      h_vld_next  = h_vld_reg & ~kill_mask;
      h_data_next = h_data_kept;
      if (store) begin
        s_valid_next = 1'b1;
        s_vld_next   = in_lane_vld;
        s_data_next  = in_data;
      end
    end else if (store) begin
      h_valid_next = 1'b1;
      h_vld_next   = in_lane_vld;
      h_data_next  = in_data;
    end

    in_ready_next = ~(h_valid_next & s_valid_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid_reg  <= 1'b0;
      h_vld_reg    <= '0;
      h_data_reg   <= '0;
      s_valid_reg  <= 1'b0;
      s_vld_reg    <= '0;
      s_data_reg   <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      h_valid_reg  <= h_valid_next;
      h_vld_reg    <= h_vld_next;
      h_data_reg   <= h_data_next;
      s_valid_reg  <= s_valid_next;
      s_vld_reg    <= s_vld_next;
      s_data_reg   <= s_data_next;
      in_ready_reg <= in_ready_next;
    end
  end

endmodule

// File: tb/tb_elastic_issue_stage.sv
// Directed bench for elastic_issue_stage (LANES=2, DATA_W=64, ZERO_ON_KILL=1)
// with hand-computed expectations.
module tb_elastic_issue_stage;

  localparam int LANES  = 2;
  localparam int DATA_W = 64;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [LANES-1:0]        kill_mask;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES-1:0]        in_lane_vld;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_lane_vld;
  logic [LANES*DATA_W-1:0] out_data;
  logic [1:0]              occupancy;

  int check_cnt = 0;
  int error_cnt = 0;

  localparam logic [127:0] GA = {64'hA1A1_0000_0000_00A1, 64'hA0A0_0000_0000_00A0};
  localparam logic [127:0] GB = {64'hB1B1_0000_0000_00B1, 64'hB0B0_0000_0000_00B0};
  localparam logic [127:0] GC = {64'hC1C1_0000_0000_00C1, 64'hC0C0_0000_0000_00C0};
  localparam logic [127:0] GD = {64'hD1D1_0000_0000_00D1, 64'hD0D0_0000_0000_00D0};
  localparam logic [127:0] GE = {64'hE1E1_0000_0000_00E1, 64'hE0E0_0000_0000_00E0};
  localparam logic [127:0] GF = {64'hF1F1_0000_0000_00F1, 64'hF0F0_0000_0000_00F0};
  localparam logic [127:0] GG = {64'h6161_0000_0000_0061, 64'h6060_0000_0000_0060};
  localparam logic [127:0] GI = {64'h1111_0000_0000_0011, 64'h1010_0000_0000_0010};

  always #5 clk = ~clk;

  elastic_issue_stage #(.LANES(LANES), .DATA_W(DATA_W), .ZERO_ON_KILL(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .kill_mask    (kill_mask),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_lane_vld  (in_lane_vld),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane_vld (out_lane_vld),
    .out_data     (out_data),
    .occupancy    (occupancy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] lanes, input logic [127:0] d);
    in_valid    = v;
    in_lane_vld = lanes;
    in_data     = d;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_occ"},       128'(occupancy),    128'(0));
    check({tag, "_in_ready"},  128'(in_ready),     128'(1));
    check({tag, "_out_valid"}, 128'(out_valid),    128'(0));
    check({tag, "_lane_vld"},  128'(out_lane_vld), 128'(0));
    check({tag, "_data"},      out_data,           128'(0));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; kill_mask = '0; out_ready = 1'b0;
    drive(1'b0, 2'b00, '0);
    tick; tick;
    rst = 1'b0;
    #1;
    check_reset_state("reset");

    // 1: back-to-back A,B,C with out_ready high
    out_ready = 1'b1;
    drive(1'b1, 2'b11, GA); tick;
    check("t1_A_data", out_data, GA);
    check("t1_A_occ", 128'(occupancy), 128'(1));
    check("t1_A_rdy", 128'(in_ready), 128'(1));
    drive(1'b1, 2'b11, GB); tick;
    check("t1_B_data", out_data, GB);
    check("t1_B_occ", 128'(occupancy), 128'(1));
    drive(1'b1, 2'b11, GC); tick;
    check("t1_C_data", out_data, GC);
    check("t1_C_vld", 128'(out_valid), 128'(1));
    check("t1_C_rdy", 128'(in_ready), 128'(1));
    drive(1'b0, 2'b00, '0); tick;
    check("t1_drain_valid", 128'(out_valid), 128'(0));
    check("t1_drain_occ", 128'(occupancy), 128'(0));

    // 2: fill head and skid with out_ready low, then drain
    out_ready = 1'b0;
    drive(1'b1, 2'b11, GA); tick;
    check("t2_occ1", 128'(occupancy), 128'(1));
    check("t2_rdy1", 128'(in_ready), 128'(1));
    drive(1'b1, 2'b11, GB); tick;
    check("t2_occ2", 128'(occupancy), 128'(2));
    check("t2_rdy0", 128'(in_ready), 128'(0));
    check("t2_holdA", out_data, GA);
    drive(1'b0, 2'b00, '0); tick;
    check("t2_holdA2", out_data, GA);
    check("t2_holdA2_lv", 128'(out_lane_vld), 128'(2'b11));
    out_ready = 1'b1; #1;
    check("t2_A_valid", 128'(out_valid), 128'(1));
    tick;
    check("t2_B_data", out_data, GB);
    check("t2_B_occ", 128'(occupancy), 128'(1));
    check("t2_B_rdy", 128'(in_ready), 128'(1));
    tick;
    check("t2_empty", 128'(occupancy), 128'(0));

    // 3: kill lane 1 of a stalled head
    out_ready = 1'b0;
    drive(1'b1, 2'b11, GD); tick;
    drive(1'b0, 2'b00, '0);
    kill_mask = 2'b10; #1;
    check("t3_lv_comb", 128'(out_lane_vld), 128'(2'b01));
    check("t3_valid", 128'(out_valid), 128'(1));
    tick;
    kill_mask = 2'b00; #1;
    check("t3_lv_reg", 128'(out_lane_vld), 128'(2'b01));
    check("t3_data", out_data, {64'h0, GD[63:0]});
    check("t3_occ", 128'(occupancy), 128'(1));

    // 4: kill the only live lane of head while skid is full
    drive(1'b1, 2'b11, GE); tick;
    check("t4_occ2", 128'(occupancy), 128'(2));
    drive(1'b0, 2'b00, '0);
    kill_mask = 2'b01; #1;
    check("t4_valid0", 128'(out_valid), 128'(0));
    tick;
    kill_mask = 2'b00; #1;
    check("t4_E_data", out_data, GE);
    check("t4_E_lv", 128'(out_lane_vld), 128'(2'b11));
    check("t4_occ1", 128'(occupancy), 128'(1));

    // 5: flush with a full stage and a group offered
    drive(1'b1, 2'b11, GF); tick;
    check("t5_occ2", 128'(occupancy), 128'(2));
    drive(1'b1, 2'b11, GG);
    flush = 1'b1; tick;
    flush = 1'b0;
    drive(1'b0, 2'b00, '0); #1;
    check("t5_occ0", 128'(occupancy), 128'(0));
    check("t5_valid0", 128'(out_valid), 128'(0));
    check("t5_rdy1", 128'(in_ready), 128'(1));
    out_ready = 1'b1; tick;
    check("t5_no_G", 128'(out_valid), 128'(0));

    // 6: bubble drop, then reset with a full stage
    out_ready = 1'b0;
    drive(1'b1, 2'b11, GI); tick;
    drive(1'b1, 2'b00, GG); #1;
    check("t6_bubble_rdy", 128'(in_ready), 128'(1));
    tick;
    check("t6_bubble_occ", 128'(occupancy), 128'(1));
    check("t6_bubble_data", out_data, GI);
    drive(1'b1, 2'b01, GA); tick;
    check("t6_occ2", 128'(occupancy), 128'(2));
    drive(1'b0, 2'b00, '0);
    rst = 1'b1; tick;
    rst = 1'b0; #1;
    check_reset_state("t6_rst");

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
